// File: rtl/logic_gates_pkg.sv
// Shared definitions for the logic gate exerciser and its golden model.
package logic_gates_pkg;

  // Exerciser FSM states (kept as plain constants for legacy tools)
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_SETTLE = 2'd1;
  localparam state_t ST_CHECK  = 2'd2;

  // Bit positions of each gate output in the result/expect masks
  localparam int BIT_AND  = 0;
  localparam int BIT_OR   = 1;
  localparam int BIT_NAND = 2;
  localparam int BIT_NOR  = 3;
  localparam int BIT_NOTB = 4;
  localparam int BIT_XOR  = 5;
  localparam int BIT_XNOR = 6;

  typedef logic [6:0] gate_mask_t;

  // Last input vector {a,b}; the run ends after checking it
  localparam logic [1:0] VEC_LAST = 2'b11;

endpackage

// File: rtl/logic_gates_expect.sv
// Golden model of the two-input gate block, in mask bit order.
module logic_gates_expect
  import logic_gates_pkg::*;
(
  input  logic       a,
  input  logic       b,
  output gate_mask_t expected
);

  // Reference truth functions for all seven gate outputs
  always_comb begin
    expected           = '0;
    expected[BIT_AND]  = a & b;
    expected[BIT_OR]   = a | b;
    expected[BIT_NAND] = ~(a & b);
    expected[BIT_NOR]  = ~(a | b);
    expected[BIT_NOTB] = ~b;
    expected[BIT_XOR]  = a ^ b;
    expected[BIT_XNOR] = ~(a ^ b);
  end

endmodule

// File: rtl/logic_gates_tester.sv
// Self-checking exerciser: walks {a,b} through 00..11, holds each vector
// SETTLE_CYCLES cycles, then compares the gate outputs on one CHECK cycle.
module logic_gates_tester
  import logic_gates_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic       and_in,
  input  logic       or_in,
  input  logic       nand_in,
  input  logic       nor_in,
  input  logic       notb_in,
  input  logic       xor_in,
  input  logic       xnor_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [1:0] first_fail_vec
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] vec;
  logic [7:0] settle_cnt;
  gate_mask_t expected;
  gate_mask_t observed;
  gate_mask_t mismatch;
  gate_mask_t mask_next;

  assign a = vec[1];
  assign b = vec[0];

  logic_gates_expect u_expect (
    .a        (a),
    .b        (b),
    .expected (expected)
  );

  // Gather gate outputs in mask order and flag per-output mismatches
  always_comb begin
    observed           = '0;
    observed[BIT_AND]  = and_in;
    observed[BIT_OR]   = or_in;
    observed[BIT_NAND] = nand_in;
    observed[BIT_NOR]  = nor_in;
    observed[BIT_NOTB] = notb_in;
    observed[BIT_XOR]  = xor_in;
    observed[BIT_XNOR] = xnor_in;
    mismatch           = observed ^ expected;
    mask_next          = fail_mask | mismatch;
  end

  // Run sequencer: settle countdown, single-cycle compare, result capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      vec            <= 2'b00;
      settle_cnt     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      fail_mask      <= '0;
      first_fail_vec <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            vec            <= 2'b00;
            settle_cnt     <= SETTLE_LOAD;
            fail_mask      <= '0;
            first_fail_vec <= 2'b00;
            pass           <= 1'b0;
            busy           <= 1'b1;
            state          <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == 8'd0) state <= ST_CHECK;
          else                    settle_cnt <= settle_cnt - 8'd1;
        end
        ST_CHECK: begin
          fail_mask <= mask_next;
          // Only the earliest failing vector is recorded
          if (mismatch != '0 && fail_mask == '0) first_fail_vec <= vec;
          if (vec == VEC_LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (mask_next == '0);
          end else begin
            vec        <= vec + 2'd1;
            settle_cnt <= SETTLE_LOAD;
            state      <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
